// File: rtl/keylock_pkg.sv
// rtl/keylock_pkg.sv - shared state encoding and CRC-8 helper for the key loader
package keylock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SHIFT  = 3'd1,
      ST_CHECK  = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_e;

   localparam int              CHK_W    = 8;
   localparam logic [CHK_W-1:0] CRC_POLY = 8'h07;

   // One MSB-first CRC-8 step: feedback is the outgoing MSB xor the new bit.
   function automatic logic [CHK_W-1:0] crc8_step(input logic [CHK_W-1:0] crc,
                                                  input logic             b);
      logic fb;
      fb = crc[CHK_W-1] ^ b;
      return {crc[CHK_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {CHK_W{1'b0}});
   endfunction

endpackage

// File: rtl/keyed_xor_reg.sv
// rtl/keyed_xor_reg.sv - registered XOR of a data bus with a key mask
module keyed_xor_reg #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   input  logic [W-1:0] mask_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;

   // Mask and data are combined in one register stage so the output never
   // shows a half-updated key.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q_q <= '0;
      end else begin
         q_q <= d_i ^ mask_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/keyed_io_mask_loader.sv
// rtl/keyed_io_mask_loader.sv - serial CRC-checked key loader driving I/O XOR masks and LUT configs
module keyed_io_mask_loader
   import keylock_pkg::*;
#(
   parameter int N_IN  = 36,
   parameter int N_OUT = 7,
   parameter int N_LUT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_valid,
   output logic               key_ready,
   input  logic               key_bit,
   input  logic               key_last,
   input  logic               clr,
   input  logic [N_IN-1:0]    in_raw,
   output logic [N_IN-1:0]    in_masked,
   input  logic [N_OUT-1:0]   core_out,
   output logic [N_OUT-1:0]   out_masked,
   output logic [4*N_LUT-1:0] lut_cfg,
   output logic               locked,
   output logic               key_err
);

   localparam int KEY_W   = N_IN + N_OUT + 4 * N_LUT;
   localparam int FRAME_W = KEY_W + CHK_W;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] KEY_CNT  = CNT_W'(KEY_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [KEY_W-1:0]   shift_q, shift_d;
   logic [KEY_W-1:0]   shadow_q, shadow_d;
   logic [CHK_W-1:0]   crc_q, crc_d;
   logic               bad_q, bad_d;
   logic               locked_q, locked_d;

   // State, frame and committed-key registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         shadow_q <= '0;
         crc_q    <= '0;
         bad_q    <= 1'b0;
         locked_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         shadow_q <= shadow_d;
         crc_q    <= crc_d;
         bad_q    <= bad_d;
         locked_q <= locked_d;
      end
   end

   // Frame sequencing: key bits feed the CRC, trailing bits are compared
   // against the CRC MSB-first by shifting the remainder out.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      shadow_d  = shadow_q;
      crc_d     = crc_q;
      bad_d     = bad_q;
      locked_d  = locked_q;
      key_ready = 1'b0;
      case (state_q)
         ST_IDLE, ST_ACTIVE: begin
            key_ready = 1'b1;
            if (key_valid) begin
               shift_d = {{(KEY_W-1){1'b0}}, key_bit};
               crc_d   = crc8_step({CHK_W{1'b0}}, key_bit);
               bad_d   = 1'b0;
               cnt_d   = CNT_W'(1);
               state_d = key_last ? ST_ERROR : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            key_ready = 1'b1;
            if (key_valid) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q < KEY_CNT) begin
                  shift_d = {shift_q[KEY_W-2:0], key_bit};
                  crc_d   = crc8_step(crc_q, key_bit);
               end else begin
                  bad_d = bad_q | (key_bit != crc_q[CHK_W-1]);
                  crc_d = {crc_q[CHK_W-2:0], 1'b0};
               end
               if (key_last) begin
                  state_d = (cnt_q == LAST_CNT) ? ST_CHECK : ST_ERROR;
               end else if (cnt_q == LAST_CNT) begin
                  state_d = ST_ERROR;
               end
            end
         end
         ST_CHECK: begin
            if (!bad_q) begin
               shadow_d = shift_q;
               locked_d = 1'b0;
               state_d  = ST_ACTIVE;
            end else begin
               state_d  = ST_ERROR;
            end
         end
         ST_ERROR: begin
            if (clr) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   keyed_xor_reg #(.W(N_IN)) u_in_mask (
      .clk_i  (clk),
      .rst_i  (rst),
      .d_i    (in_raw),
      .mask_i (shadow_q[N_IN-1:0]),
      .q_o    (in_masked)
   );

   keyed_xor_reg #(.W(N_OUT)) u_out_mask (
      .clk_i  (clk),
      .rst_i  (rst),
      .d_i    (core_out),
      .mask_i (shadow_q[N_IN+N_OUT-1:N_IN]),
      .q_o    (out_masked)
   );

   assign lut_cfg = shadow_q[KEY_W-1:N_IN+N_OUT];
   assign locked  = locked_q;
   assign key_err = (state_q == ST_ERROR);

endmodule

// File: tb/tb_keyed_io_mask_loader.sv
// tb/tb_keyed_io_mask_loader.sv - directed self-checking bench for keyed_io_mask_loader
module tb_keyed_io_mask_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_valid = 1'b0;
   logic        key_ready;
   logic        key_bit = 1'b0;
   logic        key_last = 1'b0;
   logic        clr = 1'b0;
   logic [35:0] in_raw = 36'h0;
   logic [35:0] in_masked;
   logic [6:0]  core_out = 7'h0;
   logic [6:0]  out_masked;
   logic [3:0]  lut_cfg;
   logic        locked;
   logic        key_err;

   int checks = 0;
   int errors = 0;

   localparam logic [46:0] KEY_A  = 47'h1234_5678_9ABC;
   localparam logic [46:0] KEY_B  = 47'h5A5A_A5A5_3C3C;
   localparam logic [35:0] IN_V   = 36'hF_0000_FFFF;
   localparam logic [6:0]  CORE_V = 7'h7F;
   // hand-sliced masks: A -> in 456789ABC, out 23, lut 2 ; B -> in AA5A53C3C, out 25, lut B
   localparam logic [35:0] A_IN  = 36'h4_5678_9ABC;
   localparam logic [6:0]  A_OUT = 7'h23;
   localparam logic [3:0]  A_LUT = 4'h2;
   localparam logic [35:0] B_IN  = 36'hA_A5A5_3C3C;
   localparam logic [6:0]  B_OUT = 7'h25;
   localparam logic [3:0]  B_LUT = 4'hB;

   logic [54:0] fr_a;
   logic [54:0] fr_b;

   keyed_io_mask_loader dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_bit    (key_bit),
      .key_last   (key_last),
      .clr        (clr),
      .in_raw     (in_raw),
      .in_masked  (in_masked),
      .core_out   (core_out),
      .out_masked (out_masked),
      .lut_cfg    (lut_cfg),
      .locked     (locked),
      .key_err    (key_err)
   );

   always #5 clk = ~clk;

   // CRC as polynomial long division of key * x^8 by x^8+x^2+x+1
   function automatic logic [7:0] crc_div(input logic [46:0] k);
      logic [54:0] v;
      v = {k, 8'h00};
      for (int i = 54; i >= 8; i--) begin
         if (v[i]) v[i -: 9] = v[i -: 9] ^ 9'h107;
      end
      return v[7:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives frame bits [first .. first+n-1] (MSB-first), ends on the negedge after the last accept.
   task automatic send_bits(input logic [54:0] fr, input int first, input int n,
                            input int last_idx, input bit gaps);
      for (int i = first; i < first + n; i++) begin
         if (gaps && ($urandom_range(0, 1) == 1)) begin
            @(negedge clk);
            key_valid = 1'b0;
            key_last  = 1'b0;
         end
         @(negedge clk);
         key_valid = 1'b1;
         key_bit   = fr[54-i];
         key_last  = (i == last_idx);
      end
      @(negedge clk);
      key_valid = 1'b0;
      key_last  = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      fr_a = {KEY_A, crc_div(KEY_A)};
      fr_b = {KEY_B, crc_div(KEY_B)};
      in_raw = 36'h0_0000_0001;
      repeat (2) @(negedge clk);
      check("rst_in_masked",  in_masked, 0);
      check("rst_out_masked", out_masked, 0);
      check("rst_lut",        lut_cfg, 0);
      check("rst_locked",     locked, 1);
      check("rst_key_err",    key_err, 0);
      check("rst_ready",      key_ready, 1);
      rst = 1'b0;
      @(negedge clk);
      check("pass_in_masked", in_masked, 36'h0_0000_0001);
      check("pass_locked",    locked, 1);
      check("pass_lut",       lut_cfg, 0);

      in_raw   = IN_V;
      core_out = CORE_V;

      // bad CRC before any commit
      send_bits(fr_a ^ 55'h1, 0, 55, 54, 1'b0);
      check("badcrc_check_ready", key_ready, 0);
      @(negedge clk);
      check("badcrc_err",     key_err, 1);
      check("badcrc_ready",   key_ready, 0);
      check("badcrc_locked",  locked, 1);
      check("badcrc_in",      in_masked, IN_V);
      check("badcrc_lut",     lut_cfg, 0);
      send_bits(fr_a, 0, 5, -1, 1'b0);
      check("err_ignores_bits", key_err, 1);
      do_clr();
      check("clr_err",   key_err, 0);
      check("clr_ready", key_ready, 1);

      // good frame A
      send_bits(fr_a, 0, 55, 54, 1'b0);
      check("a_check_ready",  key_ready, 0);
      check("a_check_locked", locked, 1);
      @(negedge clk);
      check("a_active_ready", key_ready, 1);
      check("a_locked",       locked, 0);
      check("a_lut",          lut_cfg, A_LUT);
      @(negedge clk);
      check("a_in_masked",  in_masked, IN_V ^ A_IN);
      check("a_out_masked", out_masked, CORE_V ^ A_OUT);

      // early key_last on bit 40
      send_bits(fr_a, 0, 41, 40, 1'b0);
      check("early_last_err",    key_err, 1);
      check("early_last_locked", locked, 0);
      do_clr();

      // overrun: 54 bits fine, 55th without last errors, 56th ignored
      send_bits(fr_b, 0, 54, -1, 1'b0);
      check("ovr54_err",   key_err, 0);
      check("ovr54_ready", key_ready, 1);
      send_bits(fr_b, 54, 1, -1, 1'b0);
      check("ovr55_err", key_err, 1);
      @(negedge clk);
      key_valid = 1'b1;
      key_bit   = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      check("ovr56_err", key_err, 1);
      check("ovr_in_masked", in_masked, IN_V ^ A_IN);
      do_clr();

      // frame B with random valid gaps
      send_bits(fr_b, 0, 55, 54, 1'b1);
      check("b_check_ready", key_ready, 0);
      @(negedge clk);
      check("b_lut", lut_cfg, B_LUT);
      @(negedge clk);
      check("b_in_masked",  in_masked, IN_V ^ B_IN);
      check("b_out_masked", out_masked, CORE_V ^ B_OUT);

      // reload from ACTIVE with bad CRC keeps B
      send_bits(fr_a ^ 55'h1, 0, 55, 54, 1'b0);
      @(negedge clk);
      check("reload_err",    key_err, 1);
      check("reload_locked", locked, 0);
      check("reload_lut",    lut_cfg, B_LUT);
      check("reload_in",     in_masked, IN_V ^ B_IN);
      check("reload_out",    out_masked, CORE_V ^ B_OUT);
      do_clr();

      // reset in mid-frame
      send_bits(fr_a, 0, 20, -1, 1'b0);
      rst = 1'b1;
      #1;
      check("midrst_in",     in_masked, 0);
      check("midrst_out",    out_masked, 0);
      check("midrst_lut",    lut_cfg, 0);
      check("midrst_locked", locked, 1);
      check("midrst_err",    key_err, 0);
      check("midrst_ready",  key_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      // fresh frame after reset commits from scratch
      send_bits(fr_a, 0, 55, 54, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("post_rst_locked", locked, 0);
      check("post_rst_in",     in_masked, IN_V ^ A_IN);
      check("post_rst_lut",    lut_cfg, A_LUT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
